// File: rtl/washing_machine_pkg.sv
// Shared types and default constants for the washing machine load classifier.
package washing_machine_pkg;

    typedef enum logic [1:0] {
        CLS_LOW   = 2'd0,
        CLS_MED   = 2'd1,
        CLS_HIGH  = 2'd2,
        CLS_XHIGH = 2'd3
    } load_class_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int unsigned DEF_WEIGHT_W   = 8;
    localparam int unsigned DEF_LEVEL_W    = 10;
    localparam int unsigned DEF_AVG_LOG2   = 2;
    localparam int unsigned DEF_STABLE_TOL = 4;
    localparam int unsigned DEF_MAX_RETRY  = 3;
    localparam int unsigned DEF_THRESH_LOW  = 20;
    localparam int unsigned DEF_THRESH_MED  = 50;
    localparam int unsigned DEF_THRESH_HIGH = 80;
    localparam int unsigned DEF_LEVEL_LOW   = 150;
    localparam int unsigned DEF_LEVEL_MED   = 300;
    localparam int unsigned DEF_LEVEL_HIGH  = 600;
    localparam int unsigned DEF_LEVEL_XHIGH = 900;

endpackage

// File: rtl/load_sample_accumulator.sv
// Sums one averaging window of load samples and tracks its min/max for the
// stability check; done_c flags the sample that completes the window.
module load_sample_accumulator #(
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         sample_en,
    input  logic [WEIGHT_W-1:0]          sample,
    output logic [WEIGHT_W+AVG_LOG2-1:0] acc,
    output logic [WEIGHT_W-1:0]          min_w,
    output logic [WEIGHT_W-1:0]          max_w,
    output logic                         done_c
);
    localparam int unsigned ACC_W = WEIGHT_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned N     = 32'd1 << AVG_LOG2;

    logic [CNT_W-1:0] count;

    assign done_c = sample_en && (count == CNT_W'(N - 1));

    // min starts at all-ones on clear so the first sample always replaces it
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
            min_w <= '0;
            max_w <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
            min_w <= '1;
            max_w <= '0;
        end else if (sample_en) begin
            acc   <= acc + ACC_W'(sample);
            count <= count + CNT_W'(1);
            if (sample < min_w) min_w <= sample;
            if (sample > max_w) max_w <= sample;
        end
    end

endmodule

// File: rtl/washing_machine_load_classifier.sv
// Averages a window of load samples, retries unstable windows and presents the
// resulting load class and water level on a valid/ready handshake.
module washing_machine_load_classifier
    import washing_machine_pkg::*;
#(
    parameter int unsigned WEIGHT_W    = DEF_WEIGHT_W,
    parameter int unsigned LEVEL_W     = DEF_LEVEL_W,
    parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
    parameter int unsigned STABLE_TOL  = DEF_STABLE_TOL,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
    parameter int unsigned THRESH_LOW  = DEF_THRESH_LOW,
    parameter int unsigned THRESH_MED  = DEF_THRESH_MED,
    parameter int unsigned THRESH_HIGH = DEF_THRESH_HIGH,
    parameter int unsigned LEVEL_LOW   = DEF_LEVEL_LOW,
    parameter int unsigned LEVEL_MED   = DEF_LEVEL_MED,
    parameter int unsigned LEVEL_HIGH  = DEF_LEVEL_HIGH,
    parameter int unsigned LEVEL_XHIGH = DEF_LEVEL_XHIGH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                sample_valid,
    input  logic [WEIGHT_W-1:0] load_weight,
    input  logic                level_ready,
    output logic                level_valid,
    output logic [LEVEL_W-1:0]  water_level,
    output logic [1:0]          load_class,
    output logic                busy,
    output logic                unstable_err
);
    localparam int unsigned ACC_W   = WEIGHT_W + AVG_LOG2;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    state_e              state, state_n;
    logic                arm_c, acc_clear_c, acc_en_c, done_c;
    logic                take_c, err_c, retry_inc_c;
    logic [ACC_W-1:0]    acc;
    logic [WEIGHT_W-1:0] min_w, max_w, avg_c, spread_c;
    logic [RETRY_W-1:0]  retry_cnt;
    load_class_e         cls_c;
    logic [LEVEL_W-1:0]  level_c;

    assign acc_en_c = (state == ACCUM) && sample_valid;
    assign avg_c    = WEIGHT_W'(acc >> AVG_LOG2);
    assign spread_c = max_w - min_w;

    load_sample_accumulator #(
        .WEIGHT_W (WEIGHT_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear_c),
        .sample_en (acc_en_c),
        .sample    (load_weight),
        .acc       (acc),
        .min_w     (min_w),
        .max_w     (max_w),
        .done_c    (done_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        arm_c       = 1'b0;
        acc_clear_c = 1'b0;
        take_c      = 1'b0;
        err_c       = 1'b0;
        retry_inc_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    arm_c       = 1'b1;
                    acc_clear_c = 1'b1;
                    state_n     = ACCUM;
                end
            end
            ACCUM: begin
                if (done_c) state_n = CHECK;
            end
            CHECK: begin
                if (spread_c <= WEIGHT_W'(STABLE_TOL)) begin
                    take_c  = 1'b1;
                    state_n = HOLD;
                end else if ((retry_cnt + RETRY_W'(1)) < RETRY_W'(MAX_RETRY)) begin
                    retry_inc_c = 1'b1;
                    acc_clear_c = 1'b1;
                    state_n     = ACCUM;
                end else begin
                    take_c  = 1'b1;
                    err_c   = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (level_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Inclusive thresholds: an average equal to a threshold stays in the lower class
    always_comb begin
        cls_c   = CLS_XHIGH;
        level_c = LEVEL_W'(LEVEL_XHIGH);
        if (avg_c <= WEIGHT_W'(THRESH_LOW)) begin
            cls_c   = CLS_LOW;
            level_c = LEVEL_W'(LEVEL_LOW);
        end else if (avg_c <= WEIGHT_W'(THRESH_MED)) begin
            cls_c   = CLS_MED;
            level_c = LEVEL_W'(LEVEL_MED);
        end else if (avg_c <= WEIGHT_W'(THRESH_HIGH)) begin
            cls_c   = CLS_HIGH;
            level_c = LEVEL_W'(LEVEL_HIGH);
        end
    end

    // Registered outputs; result fields persist through IDLE until the next result
    always_ff @(posedge clk) begin
        if (reset) begin
            level_valid  <= 1'b0;
            busy         <= 1'b0;
            water_level  <= '0;
            load_class   <= '0;
            unstable_err <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            level_valid <= (state_n == HOLD);
            busy        <= (state_n != IDLE);
            if (arm_c) begin
                retry_cnt    <= '0;
                unstable_err <= 1'b0;
            end
            if (retry_inc_c) retry_cnt <= retry_cnt + RETRY_W'(1);
            if (take_c) begin
                load_class   <= cls_c;
                water_level  <= level_c;
                unstable_err <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_washing_machine_load_classifier.sv
// Randomised and directed checks of the load classifier against a window-level
// reference model.
module tb_washing_machine_load_classifier;
    localparam int N         = 4;
    localparam int TOL       = 4;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       reset, start, sample_valid, level_ready;
    logic [7:0] load_weight;
    logic       level_valid, busy, unstable_err;
    logic [9:0] water_level;
    logic [1:0] load_class;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    washing_machine_load_classifier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sample_valid (sample_valid),
        .load_weight  (load_weight),
        .level_ready  (level_ready),
        .level_valid  (level_valid),
        .water_level  (water_level),
        .load_class   (load_class),
        .busy         (busy),
        .unstable_err (unstable_err)
    );

    // Walk windows of N samples; the first stable window or the last allowed one decides.
    function automatic void ref_result(input int q[$], output int cls, output int lvl,
                                       output int err, output int used);
        int  lv[4] = '{150, 300, 600, 900};
        int  avg = 0;
        bit  done = 0;
        err  = 0;
        used = 0;
        for (int w = 0; w < MAX_RETRY && !done; w++) begin
            int sum = 0;
            int mn = 1000;
            int mx = -1;
            for (int i = 0; i < N; i++) begin
                int s = q[w*N + i];
                sum += s;
                if (s < mn) mn = s;
                if (s > mx) mx = s;
            end
            used += N;
            avg = sum / N;
            if (mx - mn <= TOL) done = 1;
            else if (w == MAX_RETRY - 1) begin
                err  = 1;
                done = 1;
            end
        end
        cls = (avg <= 20) ? 0 : (avg <= 50) ? 1 : (avg <= 80) ? 2 : 3;
        lvl = lv[cls];
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One idle cycle after each completed window covers the CHECK cycle.
    task automatic feed(input int q[$], input int gap_max, output int early);
        early = 0;
        for (int i = 0; i < q.size(); i++) begin
            sample_valid = 1'b1;
            load_weight  = 8'(q[i]);
            @(negedge clk);
            if (level_valid) early++;
            sample_valid = 1'b0;
            if (i < q.size() - 1) begin
                int g = int'($urandom_range(gap_max, 0)) + (((i % N) == N - 1) ? 1 : 0);
                repeat (g) @(negedge clk);
            end
        end
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (!level_valid && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({level_valid, busy, unstable_err, load_class, water_level} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%0b busy=%0b err=%0b cls=%0d lvl=%0d, want all 0",
                     level_valid, busy, unstable_err, load_class, water_level);
        end
        reset = 1'b0;
        sample_valid = 1'b1;
        load_weight = 8'd99;
        @(negedge clk);
        sample_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || level_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_sample: got busy=%0b vld=%0b, want 0 0", busy, level_valid);
        end
    endtask

    task automatic test_nominal();
        int early, cyc;
        level_ready = 1'b1;
        do_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy: got %0b want 1", busy);
        end
        feed('{30, 30, 30, 30}, 0, early);
        wait_valid(10, cyc);
        checks++;
        if (early != 0 || level_valid !== 1'b1 || cyc != 1) begin
            errors++;
            $display("FAIL nominal_latency: got vld=%0b after %0d cycles early=%0d, want vld=1 after 1",
                     level_valid, cyc, early);
        end
        checks++;
        if (load_class !== 2'd1 || water_level !== 10'd300 || unstable_err !== 1'b0) begin
            errors++;
            $display("FAIL nominal_result: got cls=%0d lvl=%0d err=%0b, want 1 300 0",
                     load_class, water_level, unstable_err);
        end
        @(negedge clk);
        checks++;
        if (level_valid !== 1'b0 || busy !== 1'b0 || water_level !== 10'd300) begin
            errors++;
            $display("FAIL nominal_release: got vld=%0b busy=%0b lvl=%0d, want 0 0 300",
                     level_valid, busy, water_level);
        end
    endtask

    task automatic test_boundaries();
        int bs[8][4] = '{'{20,20,20,20}, '{21,21,21,21}, '{50,50,50,50}, '{80,80,80,80},
                         '{81,81,81,81}, '{255,255,255,255}, '{20,21,21,21}, '{80,81,82,82}};
        int ec[8] = '{0, 1, 1, 2, 3, 3, 0, 3};
        int el[8] = '{150, 300, 300, 600, 900, 900, 150, 900};
        level_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int q[$];
            int early, cyc;
            for (int j = 0; j < N; j++) q.push_back(bs[i][j]);
            do_start();
            feed(q, 1, early);
            wait_valid(10, cyc);
            checks++;
            if (level_valid !== 1'b1 || cyc != 1 || load_class !== 2'(ec[i]) ||
                water_level !== 10'(el[i]) || unstable_err !== 1'b0) begin
                errors++;
                $display("FAIL boundary_%0d: got vld=%0b cyc=%0d cls=%0d lvl=%0d err=%0b, want 1 1 %0d %0d 0",
                         i, level_valid, cyc, load_class, water_level, unstable_err, ec[i], el[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_unstable();
        int early, cyc;
        level_ready = 1'b1;
        do_start();
        feed('{10,30,10,30, 10,30,10,30, 10,30,10,30}, 0, early);
        wait_valid(10, cyc);
        checks++;
        if (early != 0 || level_valid !== 1'b1 || cyc != 1 || load_class !== 2'd0 ||
            water_level !== 10'd150 || unstable_err !== 1'b1) begin
            errors++;
            $display("FAIL unstable_giveup: got early=%0d vld=%0b cyc=%0d cls=%0d lvl=%0d err=%0b, want 0 1 1 0 150 1",
                     early, level_valid, cyc, load_class, water_level, unstable_err);
        end
        @(negedge clk);
        checks++;
        if (level_valid !== 1'b0 || unstable_err !== 1'b1 || water_level !== 10'd150) begin
            errors++;
            $display("FAIL unstable_idle_hold: got vld=%0b err=%0b lvl=%0d, want 0 1 150",
                     level_valid, unstable_err, water_level);
        end
    endtask

    task automatic test_retry_recovers();
        int early, cyc;
        level_ready = 1'b1;
        do_start();
        checks++;
        if (unstable_err !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err: got %0b want 0", unstable_err);
        end
        feed('{10,30,10,30, 60,62,61,63}, 0, early);
        sample_valid = 1'b1;
        load_weight = 8'd200;
        wait_valid(10, cyc);
        sample_valid = 1'b0;
        checks++;
        if (early != 0 || level_valid !== 1'b1 || cyc != 1 || load_class !== 2'd2 ||
            water_level !== 10'd600 || unstable_err !== 1'b0) begin
            errors++;
            $display("FAIL retry_recovers: got early=%0d vld=%0b cyc=%0d cls=%0d lvl=%0d err=%0b, want 0 1 1 2 600 0",
                     early, level_valid, cyc, load_class, water_level, unstable_err);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int early, cyc;
        level_ready = 1'b0;
        do_start();
        feed('{40, 41, 42, 43}, 0, early);
        wait_valid(10, cyc);
        for (int i = 0; i < 5; i++) begin
            start        = 1'($urandom);
            sample_valid = 1'($urandom);
            load_weight  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (level_valid !== 1'b1 || busy !== 1'b1 || load_class !== 2'd1 ||
                water_level !== 10'd300 || unstable_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen_%0d: got vld=%0b busy=%0b cls=%0d lvl=%0d err=%0b, want 1 1 1 300 0",
                         i, level_valid, busy, load_class, water_level, unstable_err);
            end
        end
        start = 1'b0;
        sample_valid = 1'b0;
        level_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (level_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got vld=%0b busy=%0b, want 0 0", level_valid, busy);
        end
        // start coinciding with the handshake must not launch a measurement
        level_ready = 1'b0;
        do_start();
        feed('{40, 41, 42, 43}, 0, early);
        wait_valid(10, cyc);
        level_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        level_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (level_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_at_handshake: got vld=%0b busy=%0b, want 0 0", level_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int early, cyc;
        level_ready = 1'b1;
        do_start();
        feed('{90, 90}, 0, early);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({level_valid, busy, unstable_err, load_class, water_level} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid: got vld=%0b busy=%0b err=%0b cls=%0d lvl=%0d, want all 0",
                     level_valid, busy, unstable_err, load_class, water_level);
        end
        reset = 1'b0;
        @(negedge clk);
        do_start();
        feed('{70, 70, 71, 72}, 0, early);
        wait_valid(10, cyc);
        checks++;
        if (level_valid !== 1'b1 || cyc != 1 || load_class !== 2'd2 ||
            water_level !== 10'd600 || unstable_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fresh: got vld=%0b cyc=%0d cls=%0d lvl=%0d err=%0b, want 1 1 2 600 0",
                     level_valid, cyc, load_class, water_level, unstable_err);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int q[$];
            int fq[$];
            int cls, lvl, err, used, early, cyc, d;
            for (int w = 0; w < MAX_RETRY; w++) begin
                if ($urandom_range(2, 0) != 0) begin
                    int base = int'($urandom_range(251, 0));
                    for (int i = 0; i < N; i++) q.push_back(base + int'($urandom_range(4, 0)));
                end else begin
                    int base = int'($urandom_range(200, 0));
                    q.push_back(base);
                    q.push_back(base + int'($urandom_range(55, 5)));
                    q.push_back(base + int'($urandom_range(5, 0)));
                    q.push_back(base + int'($urandom_range(5, 0)));
                end
            end
            ref_result(q, cls, lvl, err, used);
            for (int i = 0; i < used; i++) fq.push_back(q[i]);
            level_ready = 1'b0;
            do_start();
            feed(fq, 2, early);
            wait_valid(10, cyc);
            checks++;
            if (early != 0 || level_valid !== 1'b1 || cyc != 1 || load_class !== 2'(cls) ||
                water_level !== 10'(lvl) || unstable_err !== 1'(err)) begin
                errors++;
                $display("FAIL random_%0d: got early=%0d vld=%0b cyc=%0d cls=%0d lvl=%0d err=%0b, want 0 1 1 %0d %0d %0d",
                         t, early, level_valid, cyc, load_class, water_level, unstable_err, cls, lvl, err);
            end
            d = int'($urandom_range(3, 0));
            repeat (d) @(negedge clk);
            checks++;
            if (level_valid !== 1'b1) begin
                errors++;
                $display("FAIL random_hold_%0d: got vld=%0b want 1", t, level_valid);
            end
            level_ready = 1'b1;
            @(negedge clk);
            level_ready = 1'b0;
            checks++;
            if (level_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_release_%0d: got vld=%0b want 0", t, level_valid);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        sample_valid = 1'b0;
        level_ready  = 1'b0;
        load_weight  = 8'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_nominal();
        test_boundaries();
        test_unstable();
        test_retry_recovers();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
